// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared CP0 definitions: cause codes, register numbers, Status/Cause bit positions.
// Also provides the Status/Cause read-formatting helpers used by the top.
package cp0_exc_ctrl_pkg;

    localparam logic [4:0] EXC_CAUSE_INT  = 5'h00;
    localparam logic [4:0] EXC_CAUSE_ADEL = 5'h04;
    localparam logic [4:0] EXC_CAUSE_ADES = 5'h05;
    localparam logic [4:0] EXC_CAUSE_SYS  = 5'h08;
    localparam logic [4:0] EXC_CAUSE_BP   = 5'h09;
    localparam logic [4:0] EXC_CAUSE_RI   = 5'h0A;
    localparam logic [4:0] EXC_CAUSE_OV   = 5'h0C;
    localparam logic [4:0] EXC_CAUSE_NOP  = 5'h1F;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam int unsigned ST_IE     = 0;
    localparam int unsigned ST_EXL    = 1;
    localparam int unsigned ST_IM_LO  = 8;
    localparam int unsigned CA_EXC_LO = 2;
    localparam int unsigned CA_IP_LO  = 8;
    localparam int unsigned CA_BD     = 31;

    typedef struct packed {
        logic [7:0] im;
        logic       exl;
        logic       ie;
    } status_t;

    typedef struct packed {
        logic       bd;
        logic [5:0] ip_hw;
        logic [1:0] ip_sw;
        logic [4:0] exc;
    } cause_t;

    function automatic logic [31:0] status_rd(input status_t s);
        logic [31:0] r;
        r                  = '0;
        r[ST_IM_LO +: 8]   = s.im;
        r[ST_EXL]          = s.exl;
        r[ST_IE]           = s.ie;
        return r;
    endfunction

    function automatic logic [31:0] cause_rd(input cause_t c);
        logic [31:0] r;
        r                  = '0;
        r[CA_BD]           = c.bd;
        r[CA_IP_LO +: 8]   = {c.ip_hw, c.ip_sw};
        r[CA_EXC_LO +: 5]  = c.exc;
        return r;
    endfunction

endpackage

// File: rtl/cp0_exc_ctrl_timer.sv
// cp0_timer: Count/Compare with divide-by-2 prescale and sticky timer interrupt.
// Compiled only when CP0_TIMER_EN is defined.
`ifdef CP0_TIMER_EN
module cp0_timer (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_we_count,
    input  logic        i_we_compare,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_count,
    output logic [31:0] o_compare,
    output logic        o_timer_int
);

    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_toggle;
    logic        r_timer_int;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count     <= '0;
            r_compare   <= '0;
            r_toggle    <= 1'b0;
            r_timer_int <= 1'b0;
        end else begin
            // A software Count write overrides the pending increment and restarts the prescaler
            if (i_we_count) begin
                r_count  <= i_wdata;
                r_toggle <= 1'b0;
            end else begin
                r_toggle <= ~r_toggle;
                if (r_toggle) r_count <= r_count + 32'd1;
            end
            if (i_we_compare) begin
                r_compare   <= i_wdata;
                r_timer_int <= 1'b0;
            end else if (r_count == r_compare) begin
                r_timer_int <= 1'b1;
            end
        end
    end

    assign o_count     = r_count;
    assign o_compare   = r_compare;
    assign o_timer_int = r_timer_int;

endmodule
`endif

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception controller: sync-exception/interrupt arbitration, EPC/Status/Cause/BadVAddr.
// Define CP0_TIMER_EN to add the Count/Compare timer (cp0_timer) on IP[7].
module cp0_exc_ctrl
    import cp0_exc_ctrl_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_MEM_valid,
    input  logic [31:0] i_MEM_pc,
    input  logic        i_MEM_in_delay_slot,
    input  logic [4:0]  i_MEM_exception_cause,
    input  logic [31:0] i_MEM_bad_vaddr,
    input  logic        i_MEM_is_eret,
    input  logic        i_MEM_cp0_we,
    input  logic [4:0]  i_MEM_cp0_addr,
    input  logic [31:0] i_MEM_cp0_wdata,
    input  logic [5:0]  i_hw_int,
    output logic        o_answer_exc,
    output logic [4:0]  o_exception_cause,
    output logic [31:0] o_epc_value,
    output logic [31:0] o_cp0_rdata,
    output logic        o_timer_int
);

    status_t     r_status;
    cause_t      r_cause;
    logic [31:0] r_epc;
    logic [31:0] r_badvaddr;

    logic        w_sync_exc;
    logic        w_int_pend;
    logic        w_answer;
    logic        w_eret;
    logic        w_mtc0;
    logic        w_timer_int;
    logic [4:0]  w_rec_code;

    assign w_sync_exc = i_MEM_valid && (i_MEM_exception_cause != EXC_CAUSE_NOP);
    assign w_int_pend = r_status.ie && !r_status.exl &&
                        (|({r_cause.ip_hw, r_cause.ip_sw} & r_status.im));
    assign w_answer   = i_MEM_valid && (w_sync_exc || w_int_pend);
    assign w_eret     = i_MEM_valid && !w_answer && i_MEM_is_eret;
    assign w_mtc0     = i_MEM_valid && !w_answer && !i_MEM_is_eret && i_MEM_cp0_we;
    assign w_rec_code = w_sync_exc ? i_MEM_exception_cause : EXC_CAUSE_INT;

`ifdef CP0_TIMER_EN
    logic [31:0] w_count;
    logic [31:0] w_compare;

    cp0_timer u_timer (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_we_count   (w_mtc0 && (i_MEM_cp0_addr == CP0_COUNT)),
        .i_we_compare (w_mtc0 && (i_MEM_cp0_addr == CP0_COMPARE)),
        .i_wdata      (i_MEM_cp0_wdata),
        .o_count      (w_count),
        .o_compare    (w_compare),
        .o_timer_int  (w_timer_int)
    );
`else
    assign w_timer_int = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_status   <= '0;
            r_cause    <= '0;
            r_epc      <= '0;
            r_badvaddr <= '0;
        end else begin
            r_cause.ip_hw <= {i_hw_int[5] | w_timer_int, i_hw_int[4:0]};
            if (w_answer) begin
                r_cause.exc  <= w_rec_code;
                r_status.exl <= 1'b1;
                // A nested exception keeps the original return point
                if (!r_status.exl) begin
                    r_epc      <= i_MEM_in_delay_slot ? (i_MEM_pc - 32'd4) : i_MEM_pc;
                    r_cause.bd <= i_MEM_in_delay_slot;
                end
                if (w_sync_exc && (i_MEM_exception_cause == EXC_CAUSE_ADEL ||
                                   i_MEM_exception_cause == EXC_CAUSE_ADES))
                    r_badvaddr <= i_MEM_bad_vaddr;
            end else if (w_eret) begin
                r_status.exl <= 1'b0;
            end else if (w_mtc0) begin
                case (i_MEM_cp0_addr)
                    CP0_STATUS: begin
                        r_status.im  <= i_MEM_cp0_wdata[ST_IM_LO +: 8];
                        r_status.exl <= i_MEM_cp0_wdata[ST_EXL];
                        r_status.ie  <= i_MEM_cp0_wdata[ST_IE];
                    end
                    CP0_CAUSE: r_cause.ip_sw <= i_MEM_cp0_wdata[CA_IP_LO +: 2];
                    CP0_EPC:   r_epc         <= i_MEM_cp0_wdata;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        o_cp0_rdata = '0;
        case (i_MEM_cp0_addr)
            CP0_BADVADDR: o_cp0_rdata = r_badvaddr;
            CP0_STATUS:   o_cp0_rdata = status_rd(r_status);
            CP0_CAUSE:    o_cp0_rdata = cause_rd(r_cause);
            CP0_EPC:      o_cp0_rdata = r_epc;
`ifdef CP0_TIMER_EN
            CP0_COUNT:    o_cp0_rdata = w_count;
            CP0_COMPARE:  o_cp0_rdata = w_compare;
`endif
            default: ;
        endcase
    end

    assign o_answer_exc      = w_answer;
    assign o_exception_cause = w_sync_exc ? i_MEM_exception_cause : EXC_CAUSE_NOP;
    assign o_epc_value       = r_epc;
    assign o_timer_int       = w_timer_int;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Scoreboarded bench for cp0_exc_ctrl: directed test-plan sequence plus random traffic
// checked against an architectural CP0 model; honours CP0_TIMER_EN.
module tb_cp0_exc_ctrl;
    import cp0_exc_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, ds, eret, we;
    logic [31:0] pc, bva, wdata;
    logic [4:0]  cause, addr;
    logic [5:0]  hw;
    logic        answer, tint;
    logic [4:0]  exc_cause;
    logic [31:0] epc_out, rdata;

    always #5 clk = ~clk;

    cp0_exc_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_MEM_valid(valid), .i_MEM_pc(pc),
        .i_MEM_in_delay_slot(ds), .i_MEM_exception_cause(cause), .i_MEM_bad_vaddr(bva),
        .i_MEM_is_eret(eret), .i_MEM_cp0_we(we), .i_MEM_cp0_addr(addr),
        .i_MEM_cp0_wdata(wdata), .i_hw_int(hw), .o_answer_exc(answer),
        .o_exception_cause(exc_cause), .o_epc_value(epc_out), .o_cp0_rdata(rdata),
        .o_timer_int(tint)
    );

    typedef struct {
        logic        ans;
        logic [4:0]  cause;
        logic [31:0] epc;
        logic [31:0] rdata;
        logic        tint;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Architectural state of the reference model
    logic        m_ie, m_exl, m_bd, m_tog, m_tint;
    logic [7:0]  m_im, m_ip;
    logic [4:0]  m_exc;
    logic [31:0] m_epc, m_bva, m_count, m_cmp;

    task automatic m_reset();
        m_ie = 0; m_exl = 0; m_bd = 0; m_tog = 0; m_tint = 0;
        m_im = 0; m_ip = 0; m_exc = 0;
        m_epc = 0; m_bva = 0; m_count = 0; m_cmp = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:  return m_bva;
            5'd12: return {16'h0, m_im, 6'h0, m_exl, m_ie};
            5'd13: return {m_bd, 15'h0, m_ip, 1'b0, m_exc, 2'b00};
            5'd14: return m_epc;
`ifdef CP0_TIMER_EN
            5'd9:  return m_count;
            5'd11: return m_cmp;
`endif
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic m_sync();
        return valid && cause != EXC_CAUSE_NOP;
    endfunction

    function automatic logic m_take();
        return valid && (m_sync() || (m_ie && !m_exl && (m_ip & m_im) != 0));
    endfunction

    task automatic push_exp();
        exp_t e;
        e.ans   = m_take();
        e.cause = m_sync() ? cause : EXC_CAUSE_NOP;
        e.epc   = m_epc;
        e.rdata = m_read(addr);
        e.tint  = m_tint;
        q.push_back(e);
    endtask

    // Advance the model across one rising edge using the inputs that were applied
    task automatic m_step();
        logic       take, sync, do_eret, do_mtc0;
        logic [7:0] ip_next;
        if (!rst_n) return;
        sync    = m_sync();
        take    = m_take();
        do_eret = valid && !take && eret;
        do_mtc0 = valid && !take && !eret && we;
        ip_next = {hw[5] | m_tint, hw[4:0], m_ip[1:0]};
`ifdef CP0_TIMER_EN
        if (do_mtc0 && addr == 5'd11) m_tint = 0;
        else if (m_count == m_cmp)    m_tint = 1;
        if (do_mtc0 && addr == 5'd9) begin
            m_count = wdata; m_tog = 0;
        end else begin
            if (m_tog) m_count = m_count + 1;
            m_tog = !m_tog;
        end
        if (do_mtc0 && addr == 5'd11) m_cmp = wdata;
`endif
        if (take) begin
            m_exc = sync ? cause : EXC_CAUSE_INT;
            if (!m_exl) begin
                m_epc = ds ? pc - 4 : pc;
                m_bd  = ds;
            end
            m_exl = 1;
            if (sync && (cause == EXC_CAUSE_ADEL || cause == EXC_CAUSE_ADES)) m_bva = bva;
        end else if (do_eret) begin
            m_exl = 0;
        end else if (do_mtc0) begin
            if (addr == 5'd12) begin
                m_im = wdata[15:8]; m_exl = wdata[1]; m_ie = wdata[0];
            end else if (addr == 5'd13) begin
                ip_next[1:0] = wdata[9:8];
            end else if (addr == 5'd14) begin
                m_epc = wdata;
            end
        end
        m_ip = ip_next;
    endtask

    task automatic cycle();
        push_exp();
        @(posedge clk);
        #1;
        m_step();
    endtask

    task automatic idle(input logic v, input logic [4:0] a);
        valid = v; pc = 32'h100; ds = 0; cause = EXC_CAUSE_NOP; bva = 0;
        eret = 0; we = 0; addr = a; wdata = 0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        idle(1, a); we = 1; wdata = d;
        cycle();
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("answer", {31'h0, answer}, {31'h0, e.ans});
                chk("cause", {27'h0, exc_cause}, {27'h0, e.cause});
                chk("epc", epc_out, e.epc);
                chk("rdata", rdata, e.rdata);
                chk("timer_int", {31'h0, tint}, {31'h0, e.tint});
            end
        end
    end

    function automatic logic [4:0] rnd_cause();
        logic [4:0] c[6];
        c = '{EXC_CAUSE_ADEL, EXC_CAUSE_ADES, EXC_CAUSE_OV,
              EXC_CAUSE_SYS, EXC_CAUSE_BP, EXC_CAUSE_RI};
        return c[$urandom_range(5)];
    endfunction

    function automatic logic [4:0] rnd_addr();
        logic [4:0] a[6];
        a = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14};
        if ($urandom_range(7) == 0) return 5'($urandom);
        return a[$urandom_range(5)];
    endfunction

    initial begin : driver
        rst_n = 0; hw = 0;
        idle(0, 5'd12);
        m_reset();
        @(posedge clk);
        #1;
        cycle();
        cycle();
        rst_n = 1;
        // Reset state visible through MFC0
        idle(0, 5'd12); cycle();
        idle(1, 5'd12); cycle();
        idle(1, 5'd13); cycle();
        idle(1, 5'd14); cycle();
        // Delay-slot overflow
        idle(1, 5'd14); pc = 32'h1008; ds = 1; cause = EXC_CAUSE_OV; cycle();
        idle(1, 5'd14); cycle();
        idle(1, 5'd13); cycle();
        idle(1, 5'd12); cycle();
        // Nested address error keeps EPC, captures BadVAddr
        idle(1, 5'd8); pc = 32'h2000; bva = 32'h3; cause = EXC_CAUSE_ADEL; cycle();
        idle(1, 5'd8); cycle();
        idle(1, 5'd14); cycle();
        // ERET back to 0x4000
        mtc0(5'd14, 32'h4000);
        idle(1, 5'd12); eret = 1; cycle();
        idle(1, 5'd12); cycle();
        // Interrupt on hw_int[0] through IM[2]
        hw = 6'h01;
        mtc0(5'd12, 32'h0000_0401);
        idle(1, 5'd13); cycle();
        hw = 6'h00;
        idle(1, 5'd13); cycle();
        idle(1, 5'd12); cycle();
        // Timer: Compare = 4 from Count = 0, then clear by rewriting Compare
        mtc0(5'd12, 32'h0);
        mtc0(5'd9, 32'h0);
        mtc0(5'd11, 32'h4);
        repeat (12) begin idle(0, 5'd9); cycle(); end
        mtc0(5'd11, 32'h1000);
        idle(1, 5'd13); cycle();
        // Random traffic with an asynchronous reset in the middle
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                idle(1, 5'd14); cause = EXC_CAUSE_OV; pc = 32'h7770;
                rst_n = 0; m_reset();
                cycle(); cycle();
                rst_n = 1;
            end
            valid = ($urandom_range(9) < 8);
            pc    = $urandom & 32'hFFFF_FFFC;
            ds    = ($urandom_range(3) == 0);
            cause = ($urandom_range(5) == 0) ? rnd_cause() : EXC_CAUSE_NOP;
            bva   = $urandom;
            eret  = ($urandom_range(11) == 0);
            we    = ($urandom_range(3) == 0);
            addr  = rnd_addr();
            wdata = $urandom;
            if ($urandom_range(3) != 0) wdata[1] = 1'b0;
            if (addr == 5'd9 || addr == 5'd11) wdata = $urandom_range(64);
            hw    = ($urandom_range(5) == 0) ? 6'($urandom) : 6'h0;
            cycle();
        end
        idle(0, 5'd0); hw = 0;
        for (int k = 0; k < 5 && q.size() != 0; k++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
